// File: rtl/lambda_min_search_if.sv
`default_nettype none
// ============================================================================
//  Module   : lambda_min_search_if
//  Purpose  : Bundles the lambda input stream and the frame-result output
//             stream of lambda_min_search (two valid/ready handshakes).
//  Revision : 1.0 - initial release
// ============================================================================
interface lambda_min_search_if #(
    parameter int LAMBDA_W = 16,
    parameter int IDX_W    = 4
) ();

    // Input stream: one signed Q6.10 lambda per candidate
    logic                in_valid;
    logic                in_ready;
    logic [LAMBDA_W-1:0] in_lambda;

    // Output stream: one result per frame
    logic                out_valid;
    logic                out_ready;
    logic [LAMBDA_W-1:0] out_min;
    logic [IDX_W-1:0]    out_idx;
    logic [LAMBDA_W-1:0] out_min2;

    // Producer of lambdas / consumer of results
    modport master (
        output in_valid,
        output in_lambda,
        input  in_ready,
        input  out_valid,
        input  out_min,
        input  out_idx,
        input  out_min2,
        output out_ready
    );

    // The search block itself
    modport slave (
        input  in_valid,
        input  in_lambda,
        output in_ready,
        output out_valid,
        output out_min,
        output out_idx,
        output out_min2,
        input  out_ready
    );

endinterface
`default_nettype wire

// File: rtl/lambda_min_search.sv
`default_nettype none
// ============================================================================
//  Module   : lambda_min_search
//  Purpose  : Collects N_CAND signed Q6.10 lambda values per frame, tracks the
//             running minimum (first occurrence wins on ties) and its index,
//             then presents the frame result on an output handshake.
//  Option   : LAMBDA_MIN2_EN - when defined, also tracks the second-smallest
//             lambda (duplicates count); otherwise out_min2 is tied to 0x7FFF.
//  Revision : 1.0 - initial release
// ============================================================================
module lambda_min_search #(
    parameter int N_CAND   = 16,
    parameter int LAMBDA_W = 16,
    parameter int IDX_W    = $clog2(N_CAND)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lambda_min_search_if.slave   bus
);

    // Largest positive value: neutral starting point for a minimum search
    localparam logic [LAMBDA_W-1:0] c_LAMBDA_MAX = {1'b0, {(LAMBDA_W-1){1'b1}}};
    localparam logic [IDX_W-1:0]    c_LAST_IDX   = IDX_W'(N_CAND - 1);

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    cnt_q;
    logic [LAMBDA_W-1:0] min_q;
    logic [LAMBDA_W-1:0] min_d;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    idx_d;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [LAMBDA_W-1:0] out_min_q;
    logic [IDX_W-1:0]    out_idx_q;
`ifdef LAMBDA_MIN2_EN
    logic [LAMBDA_W-1:0] min2_q;
    logic [LAMBDA_W-1:0] min2_d;
    logic [LAMBDA_W-1:0] out_min2_q;
`endif

    logic in_xfer;
    logic out_xfer;

    // Handshakes qualified by registered state only, so no combinational
    // path exists from out_ready to in_ready or from in_valid to out_valid.
    assign in_xfer  = bus.in_valid  & (state_q == S_COLLECT);
    assign out_xfer = bus.out_ready & (state_q == S_HOLD);

    // Running min/min2/idx update for the beat currently on the bus
    always_comb begin
        min_d = min_q;
        idx_d = idx_q;
`ifdef LAMBDA_MIN2_EN
        min2_d = min2_q;
`endif
        if ($signed(bus.in_lambda) < $signed(min_q)) begin
`ifdef LAMBDA_MIN2_EN
            min2_d = min_q;
`endif
            min_d = bus.in_lambda;
            idx_d = cnt_q;
        end
`ifdef LAMBDA_MIN2_EN
        else if ($signed(bus.in_lambda) < $signed(min2_q)) begin
            // Ties with the minimum land here, so duplicates count
            min2_d = bus.in_lambda;
        end
`endif
    end

    // Frame FSM: accumulate in COLLECT, present the result in HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_COLLECT;
            cnt_q       <= '0;
            min_q       <= c_LAMBDA_MAX;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_min_q   <= c_LAMBDA_MAX;
            out_idx_q   <= '0;
`ifdef LAMBDA_MIN2_EN
            min2_q      <= c_LAMBDA_MAX;
            out_min2_q  <= c_LAMBDA_MAX;
`endif
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (in_xfer) begin
                        min_q <= min_d;
                        idx_q <= idx_d;
`ifdef LAMBDA_MIN2_EN
                        min2_q <= min2_d;
`endif
                        if (cnt_q == c_LAST_IDX) begin
                            // Latch post-update values so the final beat counts
                            out_min_q   <= min_d;
                            out_idx_q   <= idx_d;
`ifdef LAMBDA_MIN2_EN
                            out_min2_q  <= min2_d;
`endif
                            cnt_q       <= '0;
                            state_q     <= S_HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + IDX_W'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (out_xfer) begin
                        min_q       <= c_LAMBDA_MAX;
                        idx_q       <= '0;
`ifdef LAMBDA_MIN2_EN
                        min2_q      <= c_LAMBDA_MAX;
`endif
                        state_q     <= S_COLLECT;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_COLLECT;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_min   = out_min_q;
    assign bus.out_idx   = out_idx_q;
`ifdef LAMBDA_MIN2_EN
    assign bus.out_min2  = out_min2_q;
`else
    assign bus.out_min2  = c_LAMBDA_MAX;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lambda_min_search.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lambda_min_search
//  Purpose  : Self-checking bench for lambda_min_search: directed frame table,
//             async-reset mid-frame sequence and randomized frames checked
//             against a behavioural minimum/second-minimum model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lambda_min_search;

    localparam int N  = 16;
    localparam int LW = 16;
    localparam int IW = 4;

    typedef logic [LW-1:0]        lam_t;
    typedef logic [N-1:0][LW-1:0] frame_t;

    typedef struct {
        frame_t          lam;
        int              gap;
        int              hold;
        bit              garbage;
        lam_t            emin;
        logic [IW-1:0]   eidx;
        lam_t            emin2;
    } vec_t;

    logic clk;
    logic rst_n;

    lambda_min_search_if #(.LAMBDA_W(LW), .IDX_W(IW)) bus ();

    lambda_min_search #(.N_CAND(N), .LAMBDA_W(LW), .IDX_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Second minimum only exists when the option is built
    function automatic lam_t m2(input lam_t v);
`ifdef LAMBDA_MIN2_EN
        return v;
`else
        return 16'h7FFF;
`endif
    endfunction

    // Reference: minimum = smallest value, index = its first position;
    // second minimum = smallest value among all other positions.
    task automatic ref_model(input frame_t f, output lam_t mn, output logic [IW-1:0] ix,
                             output lam_t mn2);
        mn = f[0];
        ix = '0;
        for (int i = 1; i < N; i++)
            if ($signed(f[i]) < $signed(mn)) begin
                mn = f[i];
                ix = IW'(i);
            end
        mn2 = 16'h7FFF;
        for (int i = 0; i < N; i++)
            if (i != int'(ix) && $signed(f[i]) < $signed(mn2))
                mn2 = f[i];
        mn2 = m2(mn2);
    endtask

    task automatic send_frame(input frame_t f, input int gap_max);
        int n;
        for (int i = 0; i < N; i++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    bus.in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            bus.in_valid  = 1'b1;
            bus.in_lambda = f[i];
            n = 0;
            while (!bus.in_ready && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (!bus.in_ready) begin
                n_checks++;
                n_fail++;
                $display("FAIL in_ready_timeout: got 0, expected 1 within 50 cycles");
            end
            @(posedge clk); #1;
            if (i == N - 2)
                check("out_valid_before_last", 32'(bus.out_valid), 32'd0);
            if (i == N - 1) begin
                check("out_valid_after_last", 32'(bus.out_valid), 32'd1);
                check("in_ready_after_last", 32'(bus.in_ready), 32'd0);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic recv(input lam_t emin, input logic [IW-1:0] eidx, input lam_t emin2,
                        input int hold, input bit garbage);
        bus.out_ready = 1'b0;
        if (garbage) begin
            bus.in_valid  = 1'b1;
            bus.in_lambda = 16'h8000;
        end
        check("out_valid", 32'(bus.out_valid), 32'd1);
        check("out_min", 32'(bus.out_min), 32'(emin));
        check("out_idx", 32'(bus.out_idx), 32'(eidx));
        check("out_min2", 32'(bus.out_min2), 32'(emin2));
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_out_min", 32'(bus.out_min), 32'(emin));
            check("hold_out_idx", 32'(bus.out_idx), 32'(eidx));
            check("hold_out_min2", 32'(bus.out_min2), 32'(emin2));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("out_valid_after_xfer", 32'(bus.out_valid), 32'd0);
        check("in_ready_after_xfer", 32'(bus.in_ready), 32'd1);
    endtask

    vec_t          vecs[7];
    frame_t        f;
    lam_t          rmin;
    lam_t          rmin2;
    logic [IW-1:0] ridx;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_lambda = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_min", 32'(bus.out_min), 32'h7FFF);
        check("rst_out_idx", 32'(bus.out_idx), 32'd0);
        check("rst_out_min2", 32'(bus.out_min2), 32'h7FFF);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed frame table
        for (int i = 0; i < N; i++) begin
            vecs[0].lam[i] = lam_t'((15 - i) * 1024);
            vecs[1].lam[i] = (i == 0) ? 16'h1400 : (i < 3) ? 16'hF400 : 16'h1C00;
            vecs[2].lam[i] = (i == 9) ? 16'h8000 : 16'h7FFF;
            vecs[3].lam[i] = 16'h7FFF;
            vecs[4].lam[i] = 16'h8000;
            vecs[5].lam[i] = (i == 15) ? 16'h8000 : lam_t'(i * 1024);
            vecs[6].lam[i] = lam_t'((i ^ 5) * 256);
        end
        vecs[0].emin = 16'h0000; vecs[0].eidx = 4'd15; vecs[0].emin2 = m2(16'h0400);
        vecs[1].emin = 16'hF400; vecs[1].eidx = 4'd1;  vecs[1].emin2 = m2(16'hF400);
        vecs[2].emin = 16'h8000; vecs[2].eidx = 4'd9;  vecs[2].emin2 = m2(16'h7FFF);
        vecs[3].emin = 16'h7FFF; vecs[3].eidx = 4'd0;  vecs[3].emin2 = m2(16'h7FFF);
        vecs[4].emin = 16'h8000; vecs[4].eidx = 4'd0;  vecs[4].emin2 = m2(16'h8000);
        vecs[5].emin = 16'h8000; vecs[5].eidx = 4'd15; vecs[5].emin2 = m2(16'h0000);
        vecs[6].emin = 16'h0000; vecs[6].eidx = 4'd5;  vecs[6].emin2 = m2(16'h0100);
        for (int v = 0; v < 7; v++) begin
            vecs[v].gap     = (v == 6) ? 3 : 0;
            vecs[v].hold    = (v == 6) ? 10 : 0;
            vecs[v].garbage = (v == 6);
        end

        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].lam, vecs[v].gap);
            recv(vecs[v].emin, vecs[v].eidx, vecs[v].emin2, vecs[v].hold, vecs[v].garbage);
        end

        // Reset mid-frame: partial frame of 7 very small beats must be discarded
        for (int i = 0; i < 7; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_lambda = 16'h8000;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_min", 32'(bus.out_min), 32'h7FFF);
        check("midrst_out_idx", 32'(bus.out_idx), 32'd0);
        check("midrst_out_min2", 32'(bus.out_min2), 32'h7FFF);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) f[i] = lam_t'((i + 3) * 1024);
        send_frame(f, 0);
        recv(16'h0C00, 4'd0, m2(16'h1000), 0, 1'b0);

        // Randomized frames against the reference model
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 5))
                    0:       f[i] = 16'h8000;
                    1:       f[i] = 16'h7FFF;
                    2:       f[i] = lam_t'($urandom_range(0, 3)) - 16'd2;
                    default: f[i] = lam_t'($urandom);
                endcase
            end
            ref_model(f, rmin, ridx, rmin2);
            send_frame(f, $urandom_range(0, 3));
            recv(rmin, ridx, rmin2, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
